// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port. The pipeline WB stage (A) shares the port with a buffered long-latency unit (B), and a pending-write scoreboard is kept for the hazard unit.
// Optional statistics counter: define RF_ARB_STATS_EN.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_a,
  input  logic [4:0]  rd_a,
  input  logic [31:0] data_a,
  output logic        stall_a,
  input  logic        valid_b,
  output logic        ready_b,
  input  logic [4:0]  rd_b,
  input  logic [31:0] data_b,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic        rf_wr,
  output logic [4:0]  rf_wadr,
  output logic [31:0] rf_wdt,
  output logic [15:0] conflict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [3:0]      age;
  logic            src_b;
  logic [31:0]     pend;
  logic [31:0]     pend_next;

  logic   head_valid, starve, grant_a, grant_b, push, pop;
  entry_t head;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign ready_b    = (count < CW'(DEPTH));
  assign push       = valid_b && ready_b;

  // Arbitration runs only on registered FIFO state, so stall_a never depends on this cycle's B push.
  assign starve  = head_valid && (age >= 4'(STARVE_LIMIT));
  assign grant_a = valid_a && !starve;
  assign grant_b = starve || (!valid_a && head_valid);
  assign stall_a = valid_a && starve;
  assign pop     = grant_b;

  // NOTE: the FIFO storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: rd_b, data: data_b};
  end

  // Clear is applied before set so a same-cycle issue to the retiring register keeps it pending.
  always_comb begin
    pend_next = pend;
    if (rf_wr && src_b) pend_next[rf_wadr] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pend_next[iss_rd] = 1'b1;
  end

  // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      age     <= '0;
      src_b   <= 1'b0;
      rf_wr   <= 1'b0;
      rf_wadr <= '0;
      rf_wdt  <= '0;
      pend    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Age tracks how long the current head has waited; a new head starts from zero.
      if (pop || (push && !head_valid)) age <= '0;
      else if (head_valid && (age != 4'hF)) age <= age + 1'b1;

      src_b <= grant_b;
      rf_wr <= (grant_a && (rd_a != 5'd0)) || (grant_b && (head.rd != 5'd0));
      if (grant_a) begin
        rf_wadr <= rd_a;
        rf_wdt  <= data_a;
      end else if (grant_b) begin
        rf_wadr <= head.rd;
        rf_wdt  <= head.data;
      end

      pend <= pend_next;
    end
  end

  assign busy_rs1 = (chk_rs1 != 5'd0) && pend[chk_rs1];
  assign busy_rs2 = (chk_rs2 != 5'd0) && pend[chk_rs2];

`ifdef RF_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict_q <= '0;
    else if (valid_a && head_valid && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 1'b1;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0;
`endif

endmodule
